// File: rtl/hex_led_lfsr.sv
// -----------------------------------------------------------------------------
// hex_led_lfsr
//
// Purpose:
//   Small game-support block with three independent registered functions:
//     * an 8-bit XNOR Fibonacci LFSR that produces a pseudo-random number,
//     * four 2-bit digit to active-low 7-segment decoders, one register each,
//     * a "won" LED flasher that alternates two complementary patterns,
//       each pattern held for FLASH_DIV clock cycles.
//
// Parameters:
//   FLASH_DIV   clk cycles per LED flash half-period (legal range 2..1024)
//
// Ports:
//   clk            in   single clock, all registers update on its rising edge
//   Reset          in   asynchronous, active-low reset
//   switch         in   1 = advance the LFSR every cycle, 0 = hold it
//   q              out  [7:0] current LFSR state
//   digit0..digit3 in   [1:0] guessed digit values 0..3
//   hex0..hex3     out  [6:0] active-low segments {g,f,e,d,c,b,a}, 1 cycle latency
//   won            in   game-won flag, enables the LED flasher
//   ledr           out  [9:0] LED pattern
//
// Every output is taken straight from a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module hex_led_lfsr #(
    parameter int FLASH_DIV = 32
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       switch,
    output logic [7:0] q,
    input  logic [1:0] digit0,
    input  logic [1:0] digit1,
    input  logic [1:0] digit2,
    input  logic [1:0] digit3,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    input  logic       won,
    output logic [9:0] ledr
);

    localparam int                CNT_W     = $clog2(FLASH_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FLASH_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [9:0]        LED_OFF   = 10'b00_0000_0000;
    localparam logic [9:0]        LED_START = 10'b01_0101_0101;
    localparam logic [6:0]        SEG_ZERO  = 7'b100_0000;
    localparam logic [7:0]        LFSR_SEED = 8'h00;

    // Active-low 7-segment pattern for a 2-bit digit, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_encode(input logic [1:0] digit);
        logic [6:0] seg;
        case (digit)
            2'd0:    seg = 7'b100_0000;
            2'd1:    seg = 7'b111_1001;
            2'd2:    seg = 7'b010_0100;
            2'd3:    seg = 7'b011_0000;
            default: seg = 7'b111_1111;
        endcase
        return seg;
    endfunction

    // One XNOR Fibonacci step, taps 8,6,5,4. XNOR feedback makes all-zeros a
    // legal seed; the lock-up state is all-ones, which the 255-state cycle
    // starting at 00 never visits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ~(cur[7] ^ cur[5] ^ cur[4] ^ cur[3])};
    endfunction

    logic [7:0]       q_r;
    logic [7:0]       q_next_s;
    logic [6:0]       hex0_r;
    logic [6:0]       hex1_r;
    logic [6:0]       hex2_r;
    logic [6:0]       hex3_r;
    logic [9:0]       ledr_r;
    logic [9:0]       ledr_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // LFSR next-state: advance when switch is high, otherwise hold.
    always_comb begin
        q_next_s = q_r;
        if (switch) begin
            q_next_s = lfsr_next(q_r);
        end else begin
            q_next_s = q_r;
        end
    end

    // LED flasher next-state: won low clears; the first won cycle loads the
    // start pattern; afterwards the pattern inverts every FLASH_DIV cycles.
    always_comb begin
        ledr_next_s = ledr_r;
        cnt_next_s  = cnt_r;
        if (!won) begin
            ledr_next_s = LED_OFF;
            cnt_next_s  = CNT_ZERO;
        end else if (ledr_r == LED_OFF) begin
            ledr_next_s = LED_START;
            cnt_next_s  = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
            ledr_next_s = ~ledr_r;
            cnt_next_s  = CNT_ZERO;
        end else begin
            ledr_next_s = ledr_r;
            cnt_next_s  = cnt_r + CNT_ONE;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            q_r <= LFSR_SEED;
        end else begin
            q_r <= q_next_s;
        end
    end

    // Seven-segment registers; each channel follows its own digit input.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hex0_r <= SEG_ZERO;
            hex1_r <= SEG_ZERO;
            hex2_r <= SEG_ZERO;
            hex3_r <= SEG_ZERO;
        end else begin
            hex0_r <= seg_encode(digit0);
            hex1_r <= seg_encode(digit1);
            hex2_r <= seg_encode(digit2);
            hex3_r <= seg_encode(digit3);
        end
    end

    // LED pattern and phase counter registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            ledr_r <= LED_OFF;
            cnt_r  <= CNT_ZERO;
        end else begin
            ledr_r <= ledr_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    assign q    = q_r;
    assign hex0 = hex0_r;
    assign hex1 = hex1_r;
    assign hex2 = hex2_r;
    assign hex3 = hex3_r;
    assign ledr = ledr_r;

endmodule

// File: tb/tb_hex_led_lfsr.sv
// -----------------------------------------------------------------------------
// tb_hex_led_lfsr
//
// Self-checking bench for hex_led_lfsr (FLASH_DIV = 4). The reference model
// tracks the LFSR as a position in a precomputed 255-entry sequence, the hex
// outputs as a table lookup of the previous digits, and the LEDs as a
// function of how many consecutive edges won has been high.
// -----------------------------------------------------------------------------
module tb_hex_led_lfsr;

    localparam int FD = 4;

    logic       clk;
    logic       Reset;
    logic       switch;
    logic [7:0] q;
    logic [1:0] dig [4];
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic       won;
    logic [9:0] ledr;

    hex_led_lfsr #(.FLASH_DIV(FD)) dut (
        .clk    (clk),
        .Reset  (Reset),
        .switch (switch),
        .q      (q),
        .digit0 (dig[0]),
        .digit1 (dig[1]),
        .digit2 (dig[2]),
        .digit3 (dig[3]),
        .hex0   (hex0),
        .hex1   (hex1),
        .hex2   (hex2),
        .hex3   (hex3),
        .won    (won),
        .ledr   (ledr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_total;
    int         n_bad;
    logic [7:0] seq_tab [255];
    logic [6:0] seg_tab [4];
    int         lfsr_idx;
    logic [6:0] hex_exp [4];
    int         won_run;
    bit         seen [256];

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] led_exp();
        if (won_run == 0)                    return 10'b00_0000_0000;
        else if ((((won_run - 1) / FD) % 2) == 1) return 10'b10_1010_1010;
        else                                 return 10'b01_0101_0101;
    endfunction

    task automatic model_reset();
        lfsr_idx = 0;
        won_run  = 0;
        for (int i = 0; i < 4; i++) hex_exp[i] = 7'b100_0000;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_q"},    {24'd0, q},    {24'd0, seq_tab[lfsr_idx]});
        check_val({tag, "_hex0"}, {25'd0, hex0}, {25'd0, hex_exp[0]});
        check_val({tag, "_hex1"}, {25'd0, hex1}, {25'd0, hex_exp[1]});
        check_val({tag, "_hex2"}, {25'd0, hex2}, {25'd0, hex_exp[2]});
        check_val({tag, "_hex3"}, {25'd0, hex3}, {25'd0, hex_exp[3]});
        check_val({tag, "_ledr"}, {22'd0, ledr}, {22'd0, led_exp()});
    endtask

    // One clock edge: advance the model with the inputs held across the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (Reset) begin
            if (switch) lfsr_idx = (lfsr_idx + 1) % 255;
            for (int i = 0; i < 4; i++) hex_exp[i] = seg_tab[dig[i]];
            if (won) won_run++;
            else     won_run = 0;
        end
        check_all(tag);
    endtask

    // Assert Reset between edges and confirm outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        logic [7:0] s;
        n_total = 0;
        n_bad   = 0;
        seg_tab[0] = 7'b100_0000;
        seg_tab[1] = 7'b111_1001;
        seg_tab[2] = 7'b010_0100;
        seg_tab[3] = 7'b011_0000;
        s = 8'h00;
        for (int i = 0; i < 255; i++) begin
            seq_tab[i] = s;
            s = {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
        end

        Reset  = 1'b1;
        switch = 1'b0;
        won    = 1'b0;
        for (int i = 0; i < 4; i++) dig[i] = 2'd0;

        // Reset before any clock edge, then hold with busy inputs.
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_noclk");
        switch = 1'b1;
        won    = 1'b1;
        dig[0] = 2'd3;
        dig[2] = 2'd1;
        tick("rst_hold");
        tick("rst_hold");
        switch = 1'b0;
        won    = 1'b0;
        for (int i = 0; i < 4; i++) dig[i] = 2'd0;
        Reset = 1'b1;

        // Six LFSR steps from reset.
        switch = 1'b1;
        begin
            logic [7:0] exp6 [6];
            exp6[0] = 8'h01; exp6[1] = 8'h03; exp6[2] = 8'h07;
            exp6[3] = 8'h0F; exp6[4] = 8'h1E; exp6[5] = 8'h3D;
            for (int i = 0; i < 6; i++) begin
                tick("seq6");
                check_val("seq6_const", {24'd0, q}, {24'd0, exp6[i]});
            end
        end

        // Run 3, hold 5, then reset mid-run.
        async_reset("rst_mid");
        tick("rst_edge");
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) tick("run3");
        switch = 1'b0;
        for (int i = 0; i < 5; i++) tick("hold5");
        check_val("hold_07", {24'd0, q}, 32'h0000_0007);
        switch = 1'b1;
        async_reset("rst_run");
        check_val("rst_run_q", {24'd0, q}, 32'h0000_0000);
        tick("rst_edge2");
        Reset = 1'b1;

        // Full period: 255 distinct states, never FF, wraps to 00.
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[0] = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick("period");
            if (i < 254) begin
                check_val("uniq", {31'd0, seen[q]}, 32'd0);
                seen[q] = 1'b1;
            end
            check_val("no_ff", {31'd0, (q == 8'hFF)}, 32'd0);
        end
        check_val("wrap", {24'd0, q}, 32'h0000_0000);

        // Digit decoding and channel independence.
        switch = 1'b0;
        dig[3] = 2'd3; dig[2] = 2'd2; dig[1] = 2'd1; dig[0] = 2'd0;
        tick("dig");
        check_val("hex3_3", {25'd0, hex3}, {25'd0, 7'b011_0000});
        check_val("hex2_2", {25'd0, hex2}, {25'd0, 7'b010_0100});
        check_val("hex1_1", {25'd0, hex1}, {25'd0, 7'b111_1001});
        check_val("hex0_0", {25'd0, hex0}, {25'd0, 7'b100_0000});
        dig[1] = 2'd2;
        tick("dig1");
        check_val("hex1_2",  {25'd0, hex1}, {25'd0, 7'b010_0100});
        check_val("hex3_kp", {25'd0, hex3}, {25'd0, 7'b011_0000});

        // LED flashing: 4 cycles per phase, drop and re-raise mid-phase.
        won = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick("led");
            check_val("led_const", {22'd0, ledr},
                      (((i / 4) % 2) == 1) ? 32'h0000_02AA : 32'h0000_0155);
        end
        won = 1'b0;
        tick("led_drop");
        check_val("led_drop_c", {22'd0, ledr}, 32'd0);
        won = 1'b1;
        tick("led_rise");
        check_val("led_rise_c", {22'd0, ledr}, 32'h0000_0155);
        tick("led_rise2");
        tick("led_rise3");
        async_reset("rst_flash");
        tick("rst_flash_edge");
        Reset = 1'b1;

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            switch = (($urandom % 4) != 0);
            for (int i = 0; i < 4; i++)
                if (($urandom % 3) == 0) dig[i] = 2'($urandom_range(0, 3));
            if (($urandom % 10) == 0) won = ~won;
            if (($urandom % 90) == 0) begin
                async_reset("rnd_rst");
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) tick("rnd_rst_hold");
                Reset = 1'b1;
            end
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_led_lfsr.md
HEX_LED_LFSR -- requirements
Module: hex_led_lfsr

Interface
REQ-001 SHALL have parameter FLASH_DIV, default 32, clk cycles per LED flash half-period (legal range 2..1024).
REQ-002 SHALL have port clk, input, 1 bit: single clock; every register updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port switch, input, 1 bit: 1 = advance the LFSR each cycle; 0 = hold the current value.
REQ-005 SHALL have port q, output, 8 bits: current LFSR state (pseudo-random number).
REQ-006 SHALL have ports digit0..digit3, input, 2 bits each: guessed digit values 0..3.
REQ-007 SHALL have ports hex0..hex3, output, 7 bits each: active-low 7-segment patterns for digit0..digit3; bit order [6:0] = g,f,e,d,c,b,a.
REQ-008 SHALL have port won, input, 1 bit: game-won flag.
REQ-009 SHALL have port ledr, output, 10 bits: LED pattern.

Function
REQ-010 LFSR: 8-bit XNOR Fibonacci register; when switch=1, next q = {q[6:0], ~(q[7]^q[5]^q[4]^q[3])}.
REQ-011 LFSR: when switch=0, q holds.
REQ-012 LFSR: period is 255 states; the all-ones state is never reached from reset and needs no recovery logic.
REQ-013 HEX: each hexN is registered, with 1 cycle latency from digitN.
REQ-014 HEX encoding: 0 -> 1000000; 1 -> 1111001; 2 -> 0100100; 3 -> 0110000.
REQ-015 HEX: the four digit channels are independent, and each reacts to a digit change on the next edge.
REQ-016 LED: internal counter cnt, width ceil(log2(FLASH_DIV)).
REQ-017 LED, won=0: on each edge, ledr <= 0 and cnt <= 0.
REQ-018 LED, won=1 and ledr==0: ledr <= 10'b0101010101 and cnt <= 0.
REQ-019 LED, won=1 and ledr!=0 and cnt==FLASH_DIV-1: ledr <= ~ledr (all 10 bits) and cnt <= 0.
REQ-020 LED, won=1 otherwise: cnt <= cnt+1.
REQ-021 LED: each flash phase therefore lasts exactly FLASH_DIV cycles.
REQ-022 LED: a won deassertion mid-flash clears ledr on the next edge; re-assertion restarts at 0101010101.
REQ-023 No combinational path from any input to any output; all outputs come from flops.

Reset
REQ-024 Reset=0 SHALL immediately set q = 8'h00, hex0..hex3 = 1000000, ledr = 0 and cnt = 0, with no clock edge required.
REQ-025 While Reset=0, all state SHALL hold its reset value regardless of switch, digitN and won.
REQ-026 Reset release SHALL be sampled at the next rising clk; the first update occurs on the first edge with Reset=1.
REQ-027 Assertion of Reset in any state, including mid-flash or mid-sequence, SHALL take priority over all other behaviour.

Verification
REQ-028 Reset pulse, then switch=1 for 6 edges -> q sequence 01, 03, 07, 0F, 1E, 3D (hex).
REQ-029 switch=1 for 3 edges, then switch=0 for 5 edges -> q stays 07; Reset=0 mid-run -> q = 00 at once, without waiting for clk.
REQ-030 switch=1 for 255 edges from reset -> q returns to 00; no state repeats earlier and q never equals FF.
REQ-031 digit3..0 = 3,2,1,0 -> one edge later hex3=0110000, hex2=0100100, hex1=1111001, hex0=1000000; changing only digit1 to 2 -> only hex1 changes, to 0100100.
REQ-032 FLASH_DIV=4, won=1 -> ledr = 0101010101 for 4 cycles, 1010101010 for 4 cycles, then 0101010101 again.
REQ-033 FLASH_DIV=4, won dropped mid-phase -> ledr = 0 on the next edge; won re-raised -> ledr = 0101010101 on the next edge.
